// File: rtl/rdma_wr_frag.sv
// Splits each user RDMA write request into fragments of at most FRAG_BYTES and
// re-frames the payload stream so tlast closes every fragment.
module rdma_wr_frag #(
  parameter int FRAG_BYTES    = 4096,
  parameter int LEN_BITS      = 28,
  parameter int VADDR_BITS    = 48,
  parameter int PID_BITS      = 6,
  parameter int N_OUTSTANDING = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  input  logic [VADDR_BITS-1:0] s_req_vaddr,
  input  logic [LEN_BITS-1:0]   s_req_len,
  input  logic                  s_req_host,
  input  logic [PID_BITS-1:0]   s_req_pid,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [VADDR_BITS-1:0] m_req_vaddr,
  output logic [LEN_BITS-1:0]   m_req_len,
  output logic                  m_req_host,
  output logic [PID_BITS-1:0]   m_req_pid,
  output logic                  m_req_last,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [511:0]          s_axis_tdata,
  input  logic [63:0]           s_axis_tkeep,
  input  logic [PID_BITS-1:0]   s_axis_tid,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [511:0]          m_axis_tdata,
  output logic [63:0]           m_axis_tkeep,
  output logic [PID_BITS-1:0]   m_axis_tid,
  output logic                  m_axis_tlast,
  output logic                  err_tlast
);

  localparam int BEAT_W = LEN_BITS - 5;
  localparam int PTR_W  = $clog2(N_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [LEN_BITS-1:0] FRAG_LEN = LEN_BITS'(FRAG_BYTES);
  localparam logic [CNT_W-1:0]    Q_DEPTH  = CNT_W'(N_OUTSTANDING);

  typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [VADDR_BITS-1:0] vaddr_q, vaddr_d;
  logic [LEN_BITS-1:0]   rem_q, rem_d;
  logic                  host_q, host_d;
  logic [PID_BITS-1:0]   pid_q, pid_d;
  logic                  out_en_q;

  logic [BEAT_W:0]       fifo_mem [N_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  active_q, active_d;
  logic [BEAT_W-1:0]     beats_left_q, beats_left_d;
  logic                  last_frag_q, last_frag_d;
  logic                  err_q, err_d;

  logic                  q_full, q_empty, frag_last, beat_hs, final_beat, rel_pop, req_hs;
  logic [LEN_BITS-1:0]   frag_len;
  logic [BEAT_W-1:0]     frag_beats;

  assign q_full     = (cnt_q == Q_DEPTH);
  assign q_empty    = (cnt_q == {CNT_W{1'b0}});
  assign frag_last  = (rem_q <= FRAG_LEN);
  assign frag_len   = frag_last ? rem_q : FRAG_LEN;
  assign frag_beats = BEAT_W'(frag_len[LEN_BITS-1:6]) + BEAT_W'(frag_len[5:0] != 6'd0);
  assign beat_hs    = active_q & s_axis_tvalid & m_axis_tready;
  assign final_beat = (beats_left_q == BEAT_W'(1));
  // The loaded head keeps its slot until its last beat, so a full queue frees exactly then.
  assign rel_pop    = beat_hs & final_beat;
  assign req_hs     = m_req_valid & m_req_ready;
  assign rd_nxt     = rd_ptr_q + PTR_W'(1);

  assign s_req_ready   = out_en_q & (state_q == IDLE) & ~q_full;
  assign m_req_valid   = (state_q == SPLIT) & (~q_full | rel_pop);
  assign m_req_vaddr   = vaddr_q;
  assign m_req_len     = frag_len;
  assign m_req_host    = host_q;
  assign m_req_pid     = pid_q;
  assign m_req_last    = frag_last;

  assign m_axis_tvalid = active_q & s_axis_tvalid;
  assign s_axis_tready = active_q & m_axis_tready;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tid    = s_axis_tid;
  assign m_axis_tlast  = active_q & final_beat;
  assign err_tlast     = err_q;

  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    rem_d   = rem_q;
    host_d  = host_q;
    pid_d   = pid_q;
    case (state_q)
      IDLE: begin
        if (s_req_valid && s_req_ready) begin
          vaddr_d = s_req_vaddr;
          rem_d   = s_req_len;
          host_d  = s_req_host;
          pid_d   = s_req_pid;
          state_d = (s_req_len != {LEN_BITS{1'b0}}) ? SPLIT : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      SPLIT: begin
        if (req_hs) begin
          vaddr_d = vaddr_q + {{(VADDR_BITS-LEN_BITS){1'b0}}, frag_len};
          rem_d   = rem_q - frag_len;
          state_d = frag_last ? IDLE : SPLIT;
        end else begin
          state_d = SPLIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = req_hs ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = rel_pop ? rd_nxt : rd_ptr_q;
    case ({req_hs, rel_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    active_d     = active_q;
    beats_left_d = beats_left_q;
    last_frag_d  = last_frag_q;
    if (!active_q && !q_empty) begin
      active_d = 1'b1;
      {last_frag_d, beats_left_d} = fifo_mem[rd_ptr_q];
    end else if (rel_pop) begin
      // Chain straight into the next fragment when it is already queued.
      if (cnt_q > CNT_W'(1)) begin
        {last_frag_d, beats_left_d} = fifo_mem[rd_nxt];
      end else begin
        active_d = 1'b0;
      end
    end else if (beat_hs) begin
      beats_left_d = beats_left_q - BEAT_W'(1);
    end else begin
      active_d = active_q;
    end
    err_d = err_q | (beat_hs & (s_axis_tlast ^ (final_beat & last_frag_q)));
  end

  always_ff @(posedge aclk) begin
    if (req_hs) begin
      fifo_mem[wr_ptr_q] <= {frag_last, frag_beats};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      vaddr_q      <= {VADDR_BITS{1'b0}};
      rem_q        <= {LEN_BITS{1'b0}};
      host_q       <= 1'b0;
      pid_q        <= {PID_BITS{1'b0}};
      out_en_q     <= 1'b0;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      active_q     <= 1'b0;
      beats_left_q <= {BEAT_W{1'b0}};
      last_frag_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      rem_q        <= rem_d;
      host_q       <= host_d;
      pid_q        <= pid_d;
      out_en_q     <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      beats_left_q <= beats_left_d;
      last_frag_q  <= last_frag_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_rdma_wr_frag.sv
// Bench for rdma_wr_frag: a fragment-list model predicts every request and beat,
// one negedge monitor compares the DUT against it.
module tb_rdma_wr_frag;

  logic         aclk = 1'b0;
  logic         areset;
  logic         s_req_valid, s_req_ready;
  logic [47:0]  s_req_vaddr;
  logic [27:0]  s_req_len;
  logic         s_req_host;
  logic [5:0]   s_req_pid;
  logic         m_req_valid, m_req_ready;
  logic [47:0]  m_req_vaddr;
  logic [27:0]  m_req_len;
  logic         m_req_host;
  logic [5:0]   m_req_pid;
  logic         m_req_last;
  logic         s_axis_tvalid, s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic [5:0]   s_axis_tid;
  logic         s_axis_tlast;
  logic         m_axis_tvalid, m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [5:0]   m_axis_tid;
  logic         m_axis_tlast;
  logic         err_tlast;

  always #5 aclk = ~aclk;

  rdma_wr_frag dut (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_vaddr(s_req_vaddr),
    .s_req_len(s_req_len), .s_req_host(s_req_host), .s_req_pid(s_req_pid),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_vaddr(m_req_vaddr),
    .m_req_len(m_req_len), .m_req_host(m_req_host), .m_req_pid(m_req_pid), .m_req_last(m_req_last),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tid(s_axis_tid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast),
    .err_tlast(err_tlast)
  );

  typedef struct packed {
    logic [47:0] vaddr;
    logic [27:0] len;
    logic        host;
    logic [5:0]  pid;
    logic        last;
  } req_t;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [5:0]   id;
  } beat_t;

  req_t  exp_req[$];
  bit    exp_tl[$];
  beat_t exp_beat[$];
  req_t  obs_req[$];
  int    obs_tl_pos[$];

  int n_cmp = 0, n_bad = 0;
  int out_beats = 0, req_hs_cnt = 0, last_req_beats = 0;
  int base, r0, hb0;
  bit hold = 1'b0, rnd_axis = 1'b0, rnd_req = 1'b0;
  bit stalled = 1'b0;
  req_t  cur_req, held_req;
  beat_t cur_beat;

  function automatic void chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event/timeout expected none", name);
  endfunction

  // Fragment list of one user request, straight from the splitting rules.
  function automatic void model_req(input logic [47:0] va, input logic [27:0] len,
                                    input logic host, input logic [5:0] pid);
    int ln, off, f, nb;
    req_t r;
    ln  = int'(len);
    off = 0;
    while (off < ln) begin
      f       = (ln - off > 4096) ? 4096 : ln - off;
      r.vaddr = va + 48'(off);
      r.len   = 28'(f);
      r.host  = host;
      r.pid   = pid;
      r.last  = (off + f == ln);
      exp_req.push_back(r);
      nb = (f + 63) / 64;
      for (int b = 0; b < nb; b++) exp_tl.push_back(b == nb - 1);
      off += f;
    end
  endfunction

  task automatic send_req(input logic [47:0] va, input logic [27:0] len,
                          input logic host, input logic [5:0] pid);
    int t;
    bit got;
    @(posedge aclk); #1;
    s_req_valid = 1'b1; s_req_vaddr = va; s_req_len = len; s_req_host = host; s_req_pid = pid;
    t = 0; got = 1'b0;
    while (!got && t < 5000) begin
      @(negedge aclk);
      if (s_req_ready) got = 1'b1;
      else t++;
    end
    if (got) model_req(va, len, host, pid);
    else flag("s_req_timeout");
    @(posedge aclk); #1;
    s_req_valid = 1'b0;
  endtask

  task automatic send_data(input int nsend, input int total, input int err_at,
                           input logic [5:0] pid, input bit gaps);
    int t;
    bit got;
    beat_t b;
    for (int i = 0; i < nsend; i++) begin
      @(posedge aclk); #1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge aclk); #1;
      end
      for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = $urandom;
      b.keep = {$urandom, $urandom};
      b.id   = pid;
      s_axis_tvalid = 1'b1; s_axis_tdata = b.data; s_axis_tkeep = b.keep; s_axis_tid = b.id;
      s_axis_tlast  = (i == total - 1) || (i == err_at);
      exp_beat.push_back(b);
      t = 0; got = 1'b0;
      while (!got && t < 5000) begin
        @(negedge aclk);
        if (s_axis_tready) got = 1'b1;
        else t++;
      end
      if (!got) begin
        flag("s_axis_timeout");
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int t = 0;
    while (out_beats < target && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    if (out_beats < target) flag("wait_beats_timeout");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Ready generators for both downstream interfaces.
  initial begin
    m_axis_tready = 1'b1;
    m_req_ready   = 1'b1;
    forever begin
      @(posedge aclk); #1;
      m_axis_tready = hold ? 1'b0 : (rnd_axis ? 1'($urandom_range(0, 1)) : 1'b1);
      m_req_ready   = rnd_req ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every request and beat handshake against the model.
  always @(negedge aclk) begin
    if (!areset) begin
      cur_req = {m_req_vaddr, m_req_len, m_req_host, m_req_pid, m_req_last};
      if (stalled && m_req_valid) chk("m_req_stable", 640'(cur_req), 640'(held_req));
      if (m_req_valid && m_req_ready) begin
        req_hs_cnt++;
        last_req_beats = out_beats;
        obs_req.push_back(cur_req);
        if (exp_req.size() == 0) flag("m_req_unexpected");
        else chk("m_req", 640'(cur_req), 640'(exp_req.pop_front()));
      end
      stalled  = m_req_valid && !m_req_ready;
      held_req = cur_req;
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        if (m_axis_tlast) obs_tl_pos.push_back(out_beats);
        cur_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tid};
        if (exp_beat.size() == 0) flag("m_axis_beat_unexpected");
        else chk("m_axis_beat", 640'(cur_beat), 640'(exp_beat.pop_front()));
        if (exp_tl.size() == 0) flag("m_axis_tlast_unexpected");
        else chk("m_axis_tlast", 640'(m_axis_tlast), 640'(exp_tl.pop_front()));
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    s_req_valid = 1'b0; s_req_vaddr = 48'd0; s_req_len = 28'd0; s_req_host = 1'b0; s_req_pid = 6'd0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 512'd0; s_axis_tkeep = 64'd0; s_axis_tid = 6'd0; s_axis_tlast = 1'b0;
    idle(3);
    chk("rst_s_req_ready", 640'(s_req_ready), 640'(0));
    chk("rst_m_req_valid", 640'(m_req_valid), 640'(0));
    chk("rst_s_axis_tready", 640'(s_axis_tready), 640'(0));
    chk("rst_err_tlast", 640'(err_tlast), 640'(0));
    @(posedge aclk); #3;
    areset = 1'b0;
    idle(2);
    chk("post_rst_s_req_ready", 640'(s_req_ready), 640'(1));

    // 10000 B at 0x1000: three fragments, tlast on beats 64/128/157.
    obs_req.delete(); obs_tl_pos.delete(); base = out_beats;
    fork
      send_req(48'h1000, 28'd10000, 1'b1, 6'd5);
      send_data(157, 157, -1, 6'd5, 1'b0);
    join
    idle(5);
    chk("t1_nfrag", 640'(obs_req.size()), 640'(3));
    if (obs_req.size() == 3) begin
      chk("t1_f0", 640'({obs_req[0].vaddr, obs_req[0].len, obs_req[0].last}), 640'({48'h1000, 28'd4096, 1'b0}));
      chk("t1_f1", 640'({obs_req[1].vaddr, obs_req[1].len, obs_req[1].last}), 640'({48'h2000, 28'd4096, 1'b0}));
      chk("t1_f2", 640'({obs_req[2].vaddr, obs_req[2].len, obs_req[2].last}), 640'({48'h3000, 28'd1808, 1'b1}));
    end
    chk("t1_ntlast", 640'(obs_tl_pos.size()), 640'(3));
    if (obs_tl_pos.size() == 3) begin
      chk("t1_tl0", 640'(obs_tl_pos[0] - base), 640'(64));
      chk("t1_tl1", 640'(obs_tl_pos[1] - base), 640'(128));
      chk("t1_tl2", 640'(obs_tl_pos[2] - base), 640'(157));
    end
    chk("t1_err", 640'(err_tlast), 640'(0));

    // 64 B, 65 B, and a request whose second fragment address wraps.
    obs_req.delete(); obs_tl_pos.delete(); base = out_beats;
    fork
      begin
        send_req(48'h10000, 28'd64, 1'b0, 6'd1);
        send_req(48'h20040, 28'd65, 1'b1, 6'd2);
        send_req(48'hFFFF_FFFF_F800, 28'd6000, 1'b0, 6'd3);
      end
      begin
        send_data(1, 1, -1, 6'd1, 1'b0);
        send_data(2, 2, -1, 6'd2, 1'b0);
        send_data(94, 94, -1, 6'd3, 1'b1);
      end
    join
    idle(5);
    chk("t2_nfrag", 640'(obs_req.size()), 640'(4));
    if (obs_req.size() == 4) begin
      chk("t2_len64", 640'({obs_req[0].len, obs_req[0].last}), 640'({28'd64, 1'b1}));
      chk("t2_len65", 640'({obs_req[1].len, obs_req[1].last}), 640'({28'd65, 1'b1}));
      chk("t2_wrap", 640'({obs_req[3].vaddr, obs_req[3].len}), 640'({48'h800, 28'd1904}));
    end
    if (obs_tl_pos.size() >= 2) begin
      chk("t2_tl64", 640'(obs_tl_pos[0] - base), 640'(1));
      chk("t2_tl65", 640'(obs_tl_pos[1] - base), 640'(3));
    end else begin
      flag("t2_tlast_missing");
    end

    // Zero-length request: accepted, produces nothing.
    r0 = req_hs_cnt;
    send_req(48'h5000, 28'd0, 1'b0, 6'd4);
    chk("t3_ready_back", 640'(s_req_ready), 640'(1));
    idle(5);
    chk("t3_no_req", 640'(req_hs_cnt - r0), 640'(0));
    chk("t3_no_data", 640'(s_axis_tready), 640'(0));

    // Backpressure: random m_req_ready, a 20-cycle m_axis stall mid-fragment.
    base = out_beats;
    rnd_req = 1'b1;
    fork
      send_req(48'h7_0000_0040, 28'd9000, 1'b0, 6'd33);
      send_data(141, 141, -1, 6'd33, 1'b1);
      begin
        wait_beats(base + 30);
        @(posedge aclk); #1;
        hold = 1'b1; m_axis_tready = 1'b0; hb0 = out_beats;
        idle(10);
        chk("t4_hold_tready", 640'(s_axis_tready), 640'(0));
        repeat (10) @(posedge aclk);
        hold = 1'b0;
        chk("t4_hold_nobeat", 640'(out_beats), 640'(hb0));
        rnd_axis = 1'b1;
      end
    join
    rnd_req = 1'b0; rnd_axis = 1'b0;
    idle(5);
    chk("t4_beats", 640'(out_beats - base), 640'(141));

    // Queue full: 17 x 4096 B with no payload, then release the payload.
    r0 = req_hs_cnt;
    send_req(48'h100000, 28'd69632, 1'b0, 6'd2);
    idle(40);
    chk("t5_16_issued", 640'(req_hs_cnt - r0), 640'(16));
    chk("t5_valid_low", 640'(m_req_valid), 640'(0));
    base = out_beats;
    send_data(1088, 1088, -1, 6'd2, 1'b0);
    idle(5);
    chk("t5_17_issued", 640'(req_hs_cnt - r0), 640'(17));
    chk("t5_17th_at_frag_end", 640'(last_req_beats - base), 640'(63));
    chk("t5_err", 640'(err_tlast), 640'(0));

    // Early input tlast on beat 10 of a 4096 B request.
    fork
      send_req(48'h9000, 28'd4096, 1'b1, 6'd7);
      send_data(64, 64, 9, 6'd7, 1'b0);
    join
    idle(3);
    chk("t6_err_set", 640'(err_tlast), 640'(1));
    idle(10);
    chk("t6_err_sticky", 640'(err_tlast), 640'(1));

    // Reset mid-fragment, then a fresh request.
    fork
      send_req(48'hA000, 28'd4096, 1'b0, 6'd9);
      send_data(20, 64, -1, 6'd9, 1'b0);
    join
    @(posedge aclk); #1;
    hold = 1'b1; m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
    @(negedge aclk);
    chk("t7_pre_tvalid", 640'(m_axis_tvalid), 640'(1));
    @(posedge aclk); #3;
    areset = 1'b1;
    #1;
    chk("t7_rst_m_axis_tvalid", 640'(m_axis_tvalid), 640'(0));
    chk("t7_rst_s_axis_tready", 640'(s_axis_tready), 640'(0));
    chk("t7_rst_m_req_valid", 640'(m_req_valid), 640'(0));
    chk("t7_rst_s_req_ready", 640'(s_req_ready), 640'(0));
    chk("t7_rst_err", 640'(err_tlast), 640'(0));
    exp_req.delete(); exp_tl.delete(); exp_beat.delete();
    s_axis_tvalid = 1'b0; hold = 1'b0;
    repeat (3) @(posedge aclk);
    #3;
    areset = 1'b0;
    idle(2);
    chk("t7_ready_after", 640'(s_req_ready), 640'(1));
    obs_req.delete(); obs_tl_pos.delete(); base = out_beats;
    fork
      send_req(48'hB0000, 28'd200, 1'b1, 6'd3);
      send_data(4, 4, -1, 6'd3, 1'b0);
    join
    idle(5);
    chk("t7_nfrag", 640'(obs_req.size()), 640'(1));
    if (obs_req.size() == 1)
      chk("t7_frag", 640'({obs_req[0].vaddr, obs_req[0].len, obs_req[0].last}), 640'({48'hB0000, 28'd200, 1'b1}));
    if (obs_tl_pos.size() == 1) chk("t7_tl", 640'(obs_tl_pos[0] - base), 640'(4));
    else flag("t7_tlast_count");
    chk("t7_err", 640'(err_tlast), 640'(0));

    chk("end_exp_req_empty", 640'(exp_req.size()), 640'(0));
    chk("end_exp_beat_empty", 640'(exp_beat.size()), 640'(0));
    chk("end_exp_tl_empty", 640'(exp_tl.size()), 640'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
